// File: rtl/wb_uart_pkg.sv
// -----------------------------------------------------------------------------
// wb_uart_pkg
// Shared definitions for the Wishbone UART: register offsets (word index on
// wb_adr_i[3:2]), UCR bit positions, the state encoding used by both serial
// engines, and the divisor clamp helper.
// -----------------------------------------------------------------------------
package wb_uart_pkg;

  // Register word offsets
  localparam logic [1:0] REG_UCR  = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  // UCR bit positions
  localparam int UCR_RX_AVAIL     = 0;
  localparam int UCR_TX_BUSY      = 1;
  localparam int UCR_RX_OVERRUN   = 2;
  localparam int UCR_RX_FRAME_ERR = 3;

  // Smallest usable clocks-per-bit; the RX half-bit wait needs at least 2
  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Divisor actually used by an engine for a frame
  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core
// TX and RX serial shift engines. Each engine latches its own (clamped)
// divisor when a frame starts, so divisor changes never disturb a frame in
// progress.
// Ports:
//   clk_i, rst_i      system clock, asynchronous active-low reset
//   i_div             divisor register value (clocks per bit, unclamped)
//   i_tx_start        one-cycle request to start a TX frame (only when idle)
//   i_tx_data         byte to transmit
//   o_tx              serial output line, idle high
//   o_tx_busy         TX frame in progress
//   i_rx              raw asynchronous serial input
//   o_rx_done         one-cycle pulse at the stop-bit sample
//   o_rx_data         received byte, valid with o_rx_done
//   o_rx_frame_err    stop bit sampled low, valid with o_rx_done
// -----------------------------------------------------------------------------
module uart_core
  import wb_uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] i_div,
  input  logic        i_tx_start,
  input  logic [7:0]  i_tx_data,
  output logic        o_tx,
  output logic        o_tx_busy,
  input  logic        i_rx,
  output logic        o_rx_done,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_frame_err
);

  // ---------------- TX engine ----------------
  uart_state_e r_tx_state, w_tx_state_n;
  logic [15:0] r_tx_cnt,   w_tx_cnt_n;
  logic [15:0] r_tx_div,   w_tx_div_n;
  logic [2:0]  r_tx_bit,   w_tx_bit_n;
  logic [7:0]  r_tx_shift, w_tx_shift_n;
  logic        r_tx,       w_tx_n;
  logic        w_tx_last;

  assign w_tx_last = (r_tx_cnt == (r_tx_div - 16'd1));

  // TX state and datapath registers; line resets high with the async reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= 16'd0;
      r_tx_div   <= DIV_MIN;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_div   <= w_tx_div_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx       <= w_tx_n;
    end
  end

  // TX next-state: the line value for the next bit is set together with the
  // state change so uart_tx comes straight from a flop
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt;
    w_tx_div_n   = r_tx_div;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_tx_n       = r_tx;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_n = 1'b1;
        if (i_tx_start) begin
          w_tx_state_n = ST_START;
          w_tx_cnt_n   = 16'd0;
          w_tx_div_n   = clamp_div(i_div);
          w_tx_shift_n = i_tx_data;
          w_tx_n       = 1'b0;
        end else begin
          w_tx_cnt_n   = 16'd0;
        end
      end
      ST_START: begin
        if (w_tx_last) begin
          w_tx_state_n = ST_DATA;
          w_tx_cnt_n   = 16'd0;
          w_tx_bit_n   = 3'd0;
          w_tx_n       = r_tx_shift[0];
        end else begin
          w_tx_cnt_n   = r_tx_cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (w_tx_last) begin
          w_tx_cnt_n = 16'd0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_n = ST_STOP;
            w_tx_n       = 1'b1;
          end else begin
            w_tx_bit_n   = r_tx_bit + 3'd1;
            w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
            w_tx_n       = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_n = r_tx_cnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (w_tx_last) begin
          w_tx_state_n = ST_IDLE;
          w_tx_cnt_n   = 16'd0;
          w_tx_n       = 1'b1;
        end else begin
          w_tx_cnt_n   = r_tx_cnt + 16'd1;
        end
      end
      default: begin
        w_tx_state_n = ST_IDLE;
        w_tx_cnt_n   = 16'd0;
        w_tx_n       = 1'b1;
      end
    endcase
  end

  assign o_tx      = r_tx;
  assign o_tx_busy = (r_tx_state != ST_IDLE);

  // ---------------- RX engine ----------------
  logic        r_rx_sync1, r_rx_sync2, r_rx_prev;
  uart_state_e r_rx_state, w_rx_state_n;
  logic [15:0] r_rx_cnt,   w_rx_cnt_n;
  logic [15:0] r_rx_div,   w_rx_div_n;
  logic [2:0]  r_rx_bit,   w_rx_bit_n;
  logic [7:0]  r_rx_shift, w_rx_shift_n;
  logic        r_rx_done,  w_rx_done_n;
  logic        r_rx_ferr,  w_rx_ferr_n;
  logic        w_rx_fall;
  logic        w_rx_last;
  logic        w_rx_half_last;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_sync1 <= i_rx;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
    end
  end

  assign w_rx_fall      = r_rx_prev & ~r_rx_sync2;
  assign w_rx_last      = (r_rx_cnt == (r_rx_div - 16'd1));
  assign w_rx_half_last = (r_rx_cnt == ((r_rx_div >> 1) - 16'd1));

  // RX state and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_div   <= DIV_MIN;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
      r_rx_done  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_cnt   <= w_rx_cnt_n;
      r_rx_div   <= w_rx_div_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_done  <= w_rx_done_n;
      r_rx_ferr  <= w_rx_ferr_n;
    end
  end

  // RX next-state: half-bit wait to the start-bit centre, then full-bit steps
  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt;
    w_rx_div_n   = r_rx_div;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_done_n  = 1'b0;
    w_rx_ferr_n  = r_rx_ferr;
    case (r_rx_state)
      ST_IDLE: begin
        if (w_rx_fall) begin
          w_rx_state_n = ST_START;
          w_rx_cnt_n   = 16'd0;
          w_rx_div_n   = clamp_div(i_div);
        end else begin
          w_rx_cnt_n   = 16'd0;
        end
      end
      ST_START: begin
        if (w_rx_half_last) begin
          w_rx_cnt_n = 16'd0;
          w_rx_bit_n = 3'd0;
          if (r_rx_sync2) begin
            w_rx_state_n = ST_IDLE;   // glitch, not a start bit
          end else begin
            w_rx_state_n = ST_DATA;
          end
        end else begin
          w_rx_cnt_n = r_rx_cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (w_rx_last) begin
          w_rx_cnt_n   = 16'd0;
          w_rx_shift_n = {r_rx_sync2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_state_n = ST_STOP;
          end else begin
            w_rx_bit_n   = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_n = r_rx_cnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (w_rx_last) begin
          w_rx_state_n = ST_IDLE;
          w_rx_cnt_n   = 16'd0;
          w_rx_done_n  = 1'b1;
          w_rx_ferr_n  = ~r_rx_sync2;
        end else begin
          w_rx_cnt_n   = r_rx_cnt + 16'd1;
        end
      end
      default: begin
        w_rx_state_n = ST_IDLE;
        w_rx_cnt_n   = 16'd0;
      end
    endcase
  end

  assign o_rx_done      = r_rx_done;
  assign o_rx_data      = r_rx_shift;
  assign o_rx_frame_err = r_rx_ferr;

endmodule

// File: rtl/wb_uart.sv
// -----------------------------------------------------------------------------
// wb_uart
// Wishbone slave UART: register decode, status flags, divisor and RX holding
// register; serial engines live in uart_core.
// Ports:
//   clk_i, rst_i           system clock, asynchronous active-low reset
//   wb_*                   Wishbone slave (word registers on wb_adr_i[3:2])
//   uart_rx, uart_tx       serial in (asynchronous) / out, both idle high
//   irq_o                  level interrupt, equals rx_avail
// -----------------------------------------------------------------------------
module wb_uart
  import wb_uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 434
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq_o
);

  localparam logic [15:0] DIV_RST = DIVISOR[15:0];

  logic        r_ack;
  logic [31:0] r_dat;
  logic [15:0] r_div;
  logic [7:0]  r_rx_data;
  logic        r_rx_avail, r_overrun, r_frame_err;

  logic        w_req, w_wr, w_rd;
  logic [1:0]  w_reg;
  logic        w_ucr_wr, w_data_wr, w_data_rd, w_div_wr;
  logic        w_tx_start;
  logic [31:0] w_rd_data;
  logic        w_tx_busy, w_rx_done, w_rx_ferr, w_tx_line;
  logic [7:0]  w_rx_byte;
  logic        w_unused;

  assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr      = w_req & wb_we_i;
  assign w_rd      = w_req & ~wb_we_i;
  assign w_reg     = wb_adr_i[3:2];
  assign w_ucr_wr  = w_wr & (w_reg == REG_UCR)  & wb_sel_i[0];
  assign w_data_wr = w_wr & (w_reg == REG_DATA) & wb_sel_i[0];
  assign w_data_rd = w_rd & (w_reg == REG_DATA);
  assign w_div_wr  = w_wr & (w_reg == REG_DIV);
  // Writes while busy are acked but dropped
  assign w_tx_start = w_data_wr & ~w_tx_busy;

  assign w_unused = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

  // Read data mux; reserved offset and unused bits read 0
  always_comb begin
    w_rd_data = 32'd0;
    case (w_reg)
      REG_UCR: begin
        w_rd_data[UCR_RX_AVAIL]     = r_rx_avail;
        w_rd_data[UCR_TX_BUSY]      = w_tx_busy;
        w_rd_data[UCR_RX_OVERRUN]   = r_overrun;
        w_rd_data[UCR_RX_FRAME_ERR] = r_frame_err;
      end
      REG_DATA: w_rd_data[7:0]  = r_rx_data;
      REG_DIV:  w_rd_data[15:0] = r_div;
      default:  w_rd_data       = 32'd0;
    endcase
  end

  // Bus handshake: single-cycle ack with read data registered alongside it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rd_data : 32'd0;
    end
  end

  // Divisor register, byte-lane writes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_div <= DIV_RST;
    end else if (w_div_wr) begin
      if (wb_sel_i[0]) r_div[7:0]  <= wb_dat_i[7:0];
      if (wb_sel_i[1]) r_div[15:8] <= wb_dat_i[15:8];
    end
  end

  // RX holding register and status flags; a new byte's flag setting wins
  // over a same-cycle clear, and a same-cycle DATA read suppresses overrun
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_data   <= 8'd0;
      r_rx_avail  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ucr_wr) begin
        if (wb_dat_i[UCR_RX_OVERRUN])   r_overrun   <= 1'b0;
        if (wb_dat_i[UCR_RX_FRAME_ERR]) r_frame_err <= 1'b0;
      end
      if (w_rx_done) begin
        r_rx_data  <= w_rx_byte;
        r_rx_avail <= 1'b1;
        if (r_rx_avail && !w_data_rd) r_overrun <= 1'b1;
        if (w_rx_ferr) r_frame_err <= 1'b1;
      end else if (w_data_rd) begin
        r_rx_avail <= 1'b0;
      end
    end
  end

  uart_core u_core (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .i_div          (r_div),
    .i_tx_start     (w_tx_start),
    .i_tx_data      (wb_dat_i[7:0]),
    .o_tx           (w_tx_line),
    .o_tx_busy      (w_tx_busy),
    .i_rx           (uart_rx),
    .o_rx_done      (w_rx_done),
    .o_rx_data      (w_rx_byte),
    .o_rx_frame_err (w_rx_ferr)
  );

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign uart_tx  = w_tx_line;
  assign irq_o    = r_rx_avail;

endmodule

// File: doc/wb_uart.md
WB_UART -- requirements
Module: wb_uart

Interface
REQ-001 SHALL have parameter DIVISOR, default 434 (50 MHz / 115200); this is the reset value of the divisor register, in clocks per bit.
REQ-002 SHALL have port clk_i, input, 1 bit: the single system clock.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports wb_adr_i (in, 32), wb_dat_i (in, 32), wb_dat_o (out, 32), wb_sel_i (in, 4), wb_we_i (in, 1), wb_stb_i (in, 1), wb_cyc_i (in, 1) and wb_ack_o (out, 1), forming a Wishbone slave.
REQ-005 SHALL have port uart_rx, input, 1 bit: asynchronous serial input, idle high.
REQ-006 SHALL have port uart_tx, output, 1 bit: serial output, idle high.
REQ-007 SHALL have port irq_o, output, 1 bit: interrupt, level-high.

Function
REQ-008 SHALL decode registers on wb_adr_i[3:2]: 0 = UCR (status/control), 1 = DATA, 2 = DIV, 3 = reserved (reads 0, writes ignored).
REQ-009 SHALL assert wb_ack_o for exactly one cycle, one clock after wb_cyc_i & wb_stb_i & !wb_ack_o is seen; back-to-back accesses therefore take 2 cycles each.
REQ-010 SHALL register wb_dat_o in the same cycle as wb_ack_o; unused bits read 0.
REQ-011 SHALL read UCR as bit0 rx_avail, bit1 tx_busy, bit2 rx_overrun, bit3 rx_frame_err.
REQ-012 SHALL treat a UCR write with wb_sel_i[0]=1 as write-1-to-clear for bits 2 and 3; bits 0 and 1 are read-only.
REQ-013 SHALL return the RX byte on a DATA read in bits [7:0] and clear rx_avail.
REQ-014 SHALL start a TX frame on a DATA write with wb_sel_i[0]=1 and tx_busy=0; the write is still acked but dropped when tx_busy=1.
REQ-015 SHALL store DIV in 16 bits, written per byte lane (sel[0] writes [7:0], sel[1] writes [15:8]); values below 4 SHALL be used as 4.
REQ-016 SHALL latch DIV at the start of each frame, per engine; changing DIV mid-frame SHALL NOT affect the frame in progress.
REQ-017 SHALL use the TX FSM IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE, with each state lasting D clocks.
REQ-018 SHALL hold tx_busy from the clock after the accepting write until the end of the stop bit.
REQ-019 SHALL synchronise uart_rx through 2 flops before any use.
REQ-020 SHALL use the RX FSM IDLE -> START -> DATA -> STOP -> IDLE, entered on a falling edge of the synchronised input.
REQ-021 SHALL sample at mid-start-bit (D/2 clocks after the edge) and return to IDLE with no effect if the line is high there.
REQ-022 SHALL then sample 8 data bits every D clocks, followed by the stop bit.
REQ-023 SHALL store the byte at the stop sample and set rx_avail; if the stop bit is 0, the byte SHALL still be stored and rx_frame_err set.
REQ-024 SHALL handle a byte completing while rx_avail=1 by overwriting the holding register and setting rx_overrun.
REQ-025 SHALL handle a DATA read in the same cycle as byte completion by storing the new byte, leaving rx_avail=1 and not setting overrun.
REQ-026 SHALL drive irq_o = rx_avail.

Reset
REQ-027 SHALL drive, while rst_i=0: uart_tx=1, wb_ack_o=0, wb_dat_o=0, irq_o=0, all status bits 0, DIV=DIVISOR, both FSMs in IDLE.
REQ-028 SHALL abort any frame in progress when reset is asserted; uart_tx SHALL go high without waiting for a clock edge.

Structure
REQ-029 SHALL keep register offsets, UCR bit positions and FSM state encodings in the shared package wb_uart_pkg.
REQ-030 SHALL place the TX and RX shift engines in one sub-module, uart_core; wb_uart holds the Wishbone decode and registers.

Verification
REQ-031 SHALL verify reset: DIVISOR=8, release reset -> uart_tx=1, irq_o=0, UCR reads 0x0, DIV reads 0x8.
REQ-032 SHALL verify TX: DIV=8, write DATA=0xA5 -> start bit low for 8 clk, then bits 1,0,1,0,0,1,0,1 at 8 clk each, then stop high for 8 clk; tx_busy=1 for 80 clk; a second write during that time is dropped.
REQ-033 SHALL verify RX: drive 0x3C at 8 clk/bit -> irq_o=1 and UCR=0x1; DATA read returns 0x3C; UCR then reads 0x0.
REQ-034 SHALL verify overrun: send 0x11 then 0x22 with no read -> UCR=0x5 and DATA=0x22; writing 0x4 to UCR clears bit 2.
REQ-035 SHALL verify errors: a stop bit driven low -> UCR bit3=1; a 2-clk low glitch on uart_rx -> no byte and rx_avail=0.
REQ-036 SHALL verify reset mid-TX: assert rst_i at bit 3 of 0xFF -> uart_tx=1 immediately; after release, tx_busy=0 and DIV=8.
